// File: rtl/binary16_sqrt_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : binary16_sqrt_arbiter
//  Purpose  : Shares one fully pipelined binary16 square-root unit among
//             NUM_REQ requesters. Round-robin grant, at most one issue per
//             cycle, requester ID kept in an in-order tag FIFO so each result
//             is strobed back to the requester that issued it.
//  Ports    : clk_in, rst (async, active-high)
//             req_valid/req_data/req_ready  - requester operand handshake
//             resp_valid/resp_data          - one-hot result strobe + shared bus
//             sqrt_n/sqrt_valid_in          - issue side of the sqrt unit
//             sqrt_result/sqrt_valid_out    - return side of the sqrt unit
//             idle, err_orphan, issue_count - status
//  Options  : SQRT_ARB_STATS_EN - build saturating per-requester issue counters
//  Revision : 1.0 - initial release
// ============================================================================
module binary16_sqrt_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int TAG_DEPTH       = 16,
    parameter int MAX_OUTSTANDING = 14
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*16-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [15:0]             resp_data,
    output logic [15:0]             sqrt_n,
    output logic                    sqrt_valid_in,
    input  logic [15:0]             sqrt_result,
    input  logic                    sqrt_valid_out,
    output logic                    idle,
    output logic                    err_orphan,
    output logic [NUM_REQ*16-1:0]   issue_count
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_PTR_W = $clog2(TAG_DEPTH);
    localparam int c_CNT_W = $clog2(TAG_DEPTH + 1);

    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_IDX_W-1:0]   r_tag_mem [TAG_DEPTH];
    logic                 r_sqrt_valid_in;
    logic [15:0]          r_sqrt_n;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic [15:0]          r_resp_data;
    logic                 r_err_orphan;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_winner;
    logic [c_IDX_W:0]     w_sum;
    logic [c_IDX_W-1:0]   w_rr_next;
    logic                 w_can_issue;
    logic                 w_xfer;
    logic                 w_pop;
    logic [c_IDX_W-1:0]   w_pop_tag;
    logic [15:0]          w_win_data;

    // The gate uses the registered count only, so a pop in the same cycle
    // cannot re-open it until the following cycle.
    assign w_can_issue = (r_count < c_CNT_W'(MAX_OUTSTANDING));

    // Round-robin search starting at r_rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (w_sum >= (c_IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_sum[c_IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_rr_next  = (w_winner == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_xfer     = w_found & w_can_issue & ~rst;
    assign w_win_data = req_data[16*w_winner +: 16];

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // A result with no tag to pair it with is an orphan and is dropped.
    assign w_pop     = sqrt_valid_out & (r_count != '0);
    assign w_pop_tag = r_tag_mem[r_rd_ptr];

    // Tag storage needs no reset: entries are only read behind r_count.
    always_ff @(posedge clk_in) begin
        if (w_xfer) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_rr_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_sqrt_valid_in <= 1'b0;
            r_sqrt_n        <= '0;
            r_resp_valid    <= '0;
            r_resp_data     <= '0;
            r_err_orphan    <= 1'b0;
        end else begin
            r_sqrt_valid_in <= w_xfer;
            if (w_xfer) begin
                r_sqrt_n <= w_win_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_xfer, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_resp_valid <= '0;
            if (w_pop) begin
                r_resp_valid[w_pop_tag] <= 1'b1;
                r_resp_data             <= sqrt_result;
            end
            if (sqrt_valid_out && (r_count == '0)) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign sqrt_valid_in = r_sqrt_valid_in;
    assign sqrt_n        = r_sqrt_n;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign err_orphan    = r_err_orphan;
    assign idle          = (r_count == '0) && (r_wr_ptr == r_rd_ptr);

`ifdef SQRT_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [15:0] r_issue_cnt;
            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) begin
                    r_issue_cnt <= '0;
                end else if (req_ready[gi] && req_valid[gi] && (r_issue_cnt != 16'hFFFF)) begin
                    r_issue_cnt <= r_issue_cnt + 16'd1;
                end
            end
            assign issue_count[16*gi +: 16] = r_issue_cnt;
        end
    endgenerate
`else
    assign issue_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_binary16_sqrt_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_binary16_sqrt_arbiter
//  Purpose  : Scoreboard bench for binary16_sqrt_arbiter with a 13-cycle
//             behavioural sqrt unit and directed binary16 vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_binary16_sqrt_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 13;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*16-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [15:0]        resp_data;
    logic [15:0]        sqrt_n;
    logic               sqrt_valid_in;
    logic [15:0]        sqrt_result;
    logic               sqrt_valid_out;
    logic               idle;
    logic               err_orphan;
    logic [NREQ*16-1:0] issue_count;

    binary16_sqrt_arbiter #(.NUM_REQ(NREQ), .TAG_DEPTH(16), .MAX_OUTSTANDING(14)) dut (
        .clk_in(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .sqrt_n(sqrt_n), .sqrt_valid_in(sqrt_valid_in),
        .sqrt_result(sqrt_result), .sqrt_valid_out(sqrt_valid_out),
        .idle(idle), .err_orphan(err_orphan), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] op; logic [15:0] exp; } vec_t;
    typedef struct packed { logic [2:0] id; logic [15:0] exp; logic [31:0] cyc; } exp_t;
    typedef struct packed { logic [15:0] op; logic [31:0] cyc; } iss_t;

    vec_t opq [NREQ][$];
    exp_t sb [$];
    iss_t iq [$];
    int   g_id [$];
    int   g_cyc [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   resp_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural sqrt unit (13-cycle pipe) ----------------
    function automatic logic [15:0] sqrt_model(input logic [15:0] x);
        case (x)
            16'h4080: return 16'h3E00;
            16'h4400: return 16'h4000;
            16'h3C00: return 16'h3C00;
            16'h4C00: return 16'h4400;
            16'h4880: return 16'h4200;
            16'h3400: return 16'h3800;
            16'h0000: return 16'h0000;
            16'hC400: return 16'h7E00;
            default:  return 16'hFFFF;
        endcase
    endfunction

    logic [16:0] pipe [LAT];
    logic        inj_v = 1'b0;
    logic [15:0] inj_d = 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= {sqrt_valid_in, sqrt_n};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign sqrt_valid_out = pipe[LAT-1][16] | inj_v;
    assign sqrt_result    = inj_v ? inj_d : sqrt_model(pipe[LAT-1][15:0]);

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy_req();
        for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- requester driver ----------------
    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (opq[i].size() != 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[16*i +: 16] = opq[i][0].op;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        iss_t s;
        exp_t e;
        vec_t v;
        if (!rst) begin
            if (sqrt_valid_in) begin
                if (iq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_issue: got sqrt_n %0h, expected no issue", sqrt_n);
                end else begin
                    s = iq.pop_front();
                    check("sqrt_n", sqrt_n, s.op);
                    check("issue_latency", cyc - s.cyc, 1);
                end
            end
            if (resp_valid != '0) begin
                resp_seen++;
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid %0h, expected none", resp_valid);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", resp_valid, 64'(1) << e.id);
                    check("resp_data", resp_data, e.exp);
                    check("resp_latency", cyc - e.cyc, 15);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    v = opq[i].pop_front();
                    sb.push_back({3'(i), v.exp, cyc});
                    iq.push_back({v.op, cyc});
                    g_id.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        iq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        g_id.delete();
        g_cyc.delete();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || iq.size() != 0 || busy_req()) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", name, sb.size());
        end
        repeat (2) @(negedge clk);
        check({name, "_idle"}, idle, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int n;

        // Reset state, with requester 1 already waiting during reset
        opq[1].push_back({16'h4080, 16'h3E00});
        repeat (3) @(negedge clk);
        check("rst_sqrt_valid_in", sqrt_valid_in, 0);
        check("rst_sqrt_n", sqrt_n, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_issue_count", issue_count, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_idle", idle, 1);
        rst = 1'b0;

        // T1: single requester 2.25 -> 1.5, then zero and negative passthrough
        wait_drain("t1");
        opq[2].push_back({16'h0000, 16'h0000});
        opq[0].push_back({16'hC400, 16'h7E00});
        wait_drain("t1b");

        // T2: contention, all four at once
        do_reset();
        opq[0].push_back({16'h4400, 16'h4000});
        opq[1].push_back({16'h3C00, 16'h3C00});
        opq[2].push_back({16'h4C00, 16'h4400});
        opq[3].push_back({16'h4880, 16'h4200});
        wait_drain("t2");
        check("t2_grants", g_id.size(), 4);
        if (g_id.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t2_order", g_id[k], k);
                check("t2_back2back", g_cyc[k] - g_cyc[0], k);
            end
        end

        // T3: fairness between requesters 0 and 2
        do_reset();
        for (int k = 0; k < 6; k++) begin
            opq[0].push_back({16'h3400, 16'h3800});
            opq[2].push_back({16'h4400, 16'h4000});
        end
        wait_drain("t3");
        check("t3_grants", g_id.size(), 12);
        if (g_id.size() == 12) begin
            for (int k = 0; k < 12; k++) check("t3_alternate", g_id[k], (k % 2) * 2);
        end

        // T4: saturation at 14 outstanding
        do_reset();
        for (int k = 0; k < 18; k++) begin
            if (k % 2 == 0) opq[0].push_back({16'h4C00, 16'h4400});
            else            opq[0].push_back({16'h3400, 16'h3800});
        end
        wait_drain("t4");
        check("t4_grants", g_cyc.size(), 18);
        if (g_cyc.size() == 18) begin
            check("t4_first14", g_cyc[13] - g_cyc[0], 13);
            check("t4_gap", g_cyc[14] - g_cyc[13], 2);
            check("t4_resume", g_cyc[17] - g_cyc[14], 3);
        end

        // T5: reset while five ops are in flight
        do_reset();
        for (int k = 0; k < 5; k++) opq[1].push_back({16'h4880, 16'h4200});
        n = 0;
        while (g_id.size() < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_accepts", g_id.size(), 5);
        repeat (3) @(negedge clk);
        base = resp_seen;
        rst = 1'b1;
        sb.delete();
        iq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("t5_no_resp", resp_seen - base, 0);
        check("t5_idle", idle, 1);
        check("t5_err_orphan", err_orphan, 0);

        // T6: orphan result, then stats
        do_reset();
        repeat (2) @(negedge clk);
        base = resp_seen;
        @(posedge clk); #1;
        inj_v = 1'b1;
        inj_d = 16'h3C00;
        @(posedge clk); #1;
        inj_v = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_err_orphan", err_orphan, 1);
        check("t6_no_resp", resp_seen - base, 0);
        check("t6_idle", idle, 1);
        for (int k = 0; k < 3; k++) opq[3].push_back({16'h4400, 16'h4000});
        wait_drain("t6");
`ifdef SQRT_ARB_STATS_EN
        check("t6_issue_count_req3", issue_count[63:48], 3);
        check("t6_issue_count_others", issue_count[47:0], 0);
`else
        check("t6_issue_count_tied", issue_count, 0);
`endif
        check("t6_err_sticky", err_orphan, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
